iter_alu: RTL and testbench

- Parametrised, multi-cycle successor to the datapath ALU for the MIPS core; same 4-bit operation encoding.
- Adds a start/ready/done handshake and iterative unsigned multiply (shift-add) and divide (restoring), one bit per cycle.
- Produces the full 2*WIDTH product and the remainder on a HI output, and adds a signed SLT.
- Sits in EX; the pipeline stalls while ready=0.

---
 rtl/iter_alu.sv | 196 +++++++++++++++++++
 tb/tb_iter_alu.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// Multi-cycle EX-stage ALU: single-cycle logic/arith/shift ops plus iterative
// shift-add multiply and restoring divide behind a start/ready/done handshake.
module iter_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       option,
  input  logic [WIDTH-1:0] oprd1,
  input  logic [WIDTH-1:0] oprd2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic             zero,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2, S_DONE = 2'd3} state_t;

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] acc_hi_r, acc_lo_r, opb_r;
  logic [CW-1:0]    count_r;
  logic [WIDTH-1:0] result_r, hi_r;
  logic             zero_r, div_zero_r;

  logic             accept_s, last_s;
  logic [WIDTH-1:0] alu_s;
  logic [SHW-1:0]   sh_s;
  logic [WIDTH:0]   mul_sum_s, div_trial_s;
  logic [WIDTH-1:0] mul_hi_s, mul_lo_s, div_rem_s, div_quo_s;
  logic             div_ok_s;

  assign accept_s = start && ((state_r == S_IDLE) || (state_r == S_DONE));
  assign last_s   = (count_r == CW'(1));
  assign sh_s     = oprd2[SHW-1:0];

  // Single-cycle operations
  always_comb begin
    alu_s = {WIDTH{1'b0}};
    case (option)
      4'b0000: alu_s = oprd1 & oprd2;
      4'b0001: alu_s = oprd1 | oprd2;
      4'b0010: alu_s = oprd1 + oprd2;
      4'b0011: alu_s = oprd1 ^ oprd2;
      4'b0100: alu_s = oprd1 << sh_s;
      4'b0101: alu_s = oprd1 >> sh_s;
      4'b1010: alu_s = $signed(oprd1) >>> sh_s;
      4'b0110: alu_s = oprd1 - oprd2;
      4'b0111: alu_s = {{(WIDTH-1){1'b0}}, (oprd1 < oprd2)};
      4'b1011: alu_s = {{(WIDTH-1){1'b0}}, ($signed(oprd1) < $signed(oprd2))};
      4'b1100: alu_s = ~(oprd1 | oprd2);
      4'b1111: alu_s = oprd1;
      default: alu_s = {WIDTH{1'b0}};
    endcase
  end

  // One iteration step of multiply (acc_lo holds the multiplier) and divide (acc_lo holds the quotient)
  always_comb begin
    mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, opb_r} : {(WIDTH+1){1'b0}});
    mul_hi_s    = mul_sum_s[WIDTH:1];
    mul_lo_s    = {mul_sum_s[0], acc_lo_r[WIDTH-1:1]};
    div_trial_s = {acc_hi_r, acc_lo_r[WIDTH-1]} - {1'b0, opb_r};
    div_ok_s    = ~div_trial_s[WIDTH];
    if (div_ok_s) begin
      div_rem_s = div_trial_s[WIDTH-1:0];
    end else begin
      div_rem_s = {acc_hi_r[WIDTH-2:0], acc_lo_r[WIDTH-1]};
    end
    div_quo_s = {acc_lo_r[WIDTH-2:0], div_ok_s};
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = S_IDLE;
    case (state_r)
      S_IDLE, S_DONE: begin
        if (!accept_s) begin
          state_nxt_s = S_IDLE;
        end else if (option == 4'b1000) begin
          state_nxt_s = S_MUL;
        end else if ((option == 4'b1001) && (oprd2 != {WIDTH{1'b0}})) begin
          state_nxt_s = S_DIV;
        end else begin
          state_nxt_s = S_DONE;
        end
      end
      S_MUL:   state_nxt_s = last_s ? S_DONE : S_MUL;
      S_DIV:   state_nxt_s = last_s ? S_DONE : S_DIV;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    ready = 1'b0;
    done  = 1'b0;
    case (state_r)
      S_IDLE:  ready = 1'b1;
      S_DONE: begin
        ready = 1'b1;
        done  = 1'b1;
      end
      default: begin
        ready = 1'b0;
        done  = 1'b0;
      end
    endcase
  end

  // Datapath: operand capture, iteration, and result registers updated only when entering DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_hi_r   <= {WIDTH{1'b0}};
      acc_lo_r   <= {WIDTH{1'b0}};
      opb_r      <= {WIDTH{1'b0}};
      count_r    <= {CW{1'b0}};
      result_r   <= {WIDTH{1'b0}};
      hi_r       <= {WIDTH{1'b0}};
      zero_r     <= 1'b1;
      div_zero_r <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE, S_DONE: begin
          if (accept_s) begin
            if (option == 4'b1000) begin
              acc_hi_r <= {WIDTH{1'b0}};
              acc_lo_r <= oprd2;
              opb_r    <= oprd1;
              count_r  <= CW'(WIDTH);
            end else if (option == 4'b1001) begin
              if (oprd2 == {WIDTH{1'b0}}) begin
                result_r   <= {WIDTH{1'b1}};
                hi_r       <= oprd1;
                zero_r     <= 1'b0;
                div_zero_r <= 1'b1;
              end else begin
                acc_hi_r <= {WIDTH{1'b0}};
                acc_lo_r <= oprd1;
                opb_r    <= oprd2;
                count_r  <= CW'(WIDTH);
              end
            end else begin
              result_r   <= alu_s;
              hi_r       <= {WIDTH{1'b0}};
              zero_r     <= (alu_s == {WIDTH{1'b0}});
              div_zero_r <= 1'b0;
            end
          end
        end
        S_MUL: begin
          acc_hi_r <= mul_hi_s;
          acc_lo_r <= mul_lo_s;
          count_r  <= count_r - CW'(1);
          if (last_s) begin
            result_r   <= mul_lo_s;
            hi_r       <= mul_hi_s;
            zero_r     <= (mul_lo_s == {WIDTH{1'b0}});
            div_zero_r <= 1'b0;
          end
        end
        S_DIV: begin
          acc_hi_r <= div_rem_s;
          acc_lo_r <= div_quo_s;
          count_r  <= count_r - CW'(1);
          if (last_s) begin
            result_r   <= div_quo_s;
            hi_r       <= div_rem_s;
            zero_r     <= (div_quo_s == {WIDTH{1'b0}});
            div_zero_r <= 1'b0;
          end
        end
        default: count_r <= {CW{1'b0}};
      endcase
    end
  end

  assign result   = result_r;
  assign hi       = hi_r;
  assign zero     = zero_r;
  assign div_zero = div_zero_r;

endmodule

// File: tb/tb_iter_alu.sv
// Scoreboard bench for iter_alu: directed vectors push expected responses,
// per-instance monitors pop and compare on every done pulse.
module tb_iter_alu;

  typedef struct {
    logic [31:0] r;
    logic [31:0] h;
    logic        z;
    logic        dz;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  exp_t        q32[$];
  exp_t        q8[$];

  logic        start32 = 1'b0;
  logic [3:0]  op32 = 4'd0;
  logic [31:0] a32 = 32'd0, b32 = 32'd0;
  logic        ready32, done32, zero32, dz32;
  logic [31:0] result32, hi32;

  logic        start8 = 1'b0;
  logic [3:0]  op8 = 4'd0;
  logic [7:0]  a8 = 8'd0, b8 = 8'd0;
  logic        ready8, done8, zero8, dz8;
  logic [7:0]  result8, hi8;

  iter_alu #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .start(start32), .option(op32), .oprd1(a32), .oprd2(b32),
    .ready(ready32), .done(done32), .result(result32), .hi(hi32), .zero(zero32), .div_zero(dz32)
  );

  iter_alu #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .option(op8), .oprd1(a8), .oprd2(b8),
    .ready(ready8), .done(done8), .result(result8), .hi(hi8), .zero(zero8), .div_zero(dz8)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor for the 32-bit instance
  always @(negedge clk) begin
    if (rst_n && done32) begin
      if (q32.size() == 0) begin
        chk("unexpected_done32", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q32.pop_front();
        chk("result32", {32'd0, result32}, {32'd0, e.r});
        chk("hi32", {32'd0, hi32}, {32'd0, e.h});
        chk("zero32", {63'd0, zero32}, {63'd0, e.z});
        chk("div_zero32", {63'd0, dz32}, {63'd0, e.dz});
        chk("latency32", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  // Monitor for the 8-bit instance
  always @(negedge clk) begin
    if (rst_n && done8) begin
      if (q8.size() == 0) begin
        chk("unexpected_done8", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        chk("result8", {56'd0, result8}, {32'd0, e.r});
        chk("hi8", {56'd0, hi8}, {32'd0, e.h});
        chk("zero8", {63'd0, zero8}, {63'd0, e.z});
        chk("div_zero8", {63'd0, dz8}, {63'd0, e.dz});
        chk("latency8", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  task automatic issue32(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic [31:0] eh, input logic edz,
                         input int lat, input bit push);
    int n = 0;
    @(negedge clk);
    while (!ready32 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready32) chk("ready_timeout32", 64'd0, 64'd1);
    start32 = 1'b1; op32 = op; a32 = a; b32 = b;
    if (push) q32.push_back('{er, eh, (er == 32'd0), edz, cyc + lat});
    @(posedge clk);
    #1 start32 = 1'b0;
  endtask

  task automatic issue8(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic [7:0] eh, input int lat);
    int n = 0;
    @(negedge clk);
    while (!ready8 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready8) chk("ready_timeout8", 64'd0, 64'd1);
    start8 = 1'b1; op8 = op; a8 = a; b8 = b;
    q8.push_back('{{24'd0, er}, {24'd0, eh}, (er == 8'd0), 1'b0, cyc + lat});
    @(posedge clk);
    #1 start8 = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_ready"}, {63'd0, ready32}, 64'd1);
    chk({tag, "_done"}, {63'd0, done32}, 64'd0);
    chk({tag, "_result"}, {32'd0, result32}, 64'd0);
    chk({tag, "_hi"}, {32'd0, hi32}, 64'd0);
    chk({tag, "_zero"}, {63'd0, zero32}, 64'd1);
    chk({tag, "_div_zero"}, {63'd0, dz32}, 64'd0);
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Back-to-back simple ops
    issue32(4'b0010, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0, 1'b0, 1, 1'b1);
    issue32(4'b0110, 32'd5,         32'd7,         32'hFFFF_FFFE, 32'h0, 1'b0, 1, 1'b1);
    issue32(4'b0000, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 32'h0, 1'b0, 1, 1'b1);
    issue32(4'b0001, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 32'h0, 1'b0, 1, 1'b1);
    issue32(4'b0011, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 32'h0, 1'b0, 1, 1'b1);
    issue32(4'b1100, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h000F_F000, 32'h0, 1'b0, 1, 1'b1);
    issue32(4'b0100, 32'h1,         32'h4,         32'h10,        32'h0, 1'b0, 1, 1'b1);
    issue32(4'b0101, 32'h8000_0000, 32'h3F,        32'h1,         32'h0, 1'b0, 1, 1'b1);
    issue32(4'b1010, 32'h8000_0000, 32'h3F,        32'hFFFF_FFFF, 32'h0, 1'b0, 1, 1'b1);
    issue32(4'b1011, 32'hFFFF_FFFF, 32'h1,         32'h1,         32'h0, 1'b0, 1, 1'b1);
    issue32(4'b0111, 32'hFFFF_FFFF, 32'h1,         32'h0,         32'h0, 1'b0, 1, 1'b1);
    issue32(4'b1111, 32'h1234_5678, 32'h0,         32'h1234_5678, 32'h0, 1'b0, 1, 1'b1);
    issue32(4'b1101, 32'h1234_5678, 32'h1,         32'h0,         32'h0, 1'b0, 1, 1'b1);

    // MUL with a start pulse mid-operation that must be ignored
    issue32(4'b1000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 32'h1, 1'b0, 33, 1'b1);
    repeat (9) @(negedge clk);
    chk("busy_ready32", {63'd0, ready32}, 64'd0);
    start32 = 1'b1; op32 = 4'b0010; a32 = 32'd1; b32 = 32'd1;
    @(negedge clk);
    start32 = 1'b0;

    // Divide, divide-by-zero, and a following op clearing div_zero
    issue32(4'b1001, 32'd100, 32'd7, 32'd14,        32'd2, 1'b0, 33, 1'b1);
    issue32(4'b1001, 32'd9,   32'd0, 32'hFFFF_FFFF, 32'd9, 1'b1, 1,  1'b1);
    issue32(4'b0010, 32'd3,   32'd4, 32'd7,         32'd0, 1'b0, 1,  1'b1);

    n = 0;
    while (q32.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q32.size() != 0) chk("drain_timeout32", 64'(q32.size()), 64'd0);

    // Reset during MUL: no done, outputs back to reset values
    issue32(4'b1000, 32'd3, 32'd5, 32'd0, 32'd0, 1'b0, 33, 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk_reset_outputs("midop_reset");
    repeat (40) @(negedge clk);
    chk("after_abort_ready", {63'd0, ready32}, 64'd1);

    // Narrow instance
    issue8(4'b1000, 8'hFF, 8'hFF, 8'h01, 8'hFE, 9);
    issue8(4'b1001, 8'd200, 8'd13, 8'd15, 8'd5, 9);

    n = 0;
    while ((q8.size() != 0 || q32.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q8.size() != 0) chk("drain_timeout8", 64'(q8.size()), 64'd0);
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
